// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2,
    LAT_DIV  = 2'd3
  } lat_class_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request bundle and pipeline-control responses of the scoreboard.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int RA_W     = 5
);
  logic                id_valid;
  logic [RA_W-1:0]     id_rs;
  logic [RA_W-1:0]     id_rt;
  logic                id_rs_used;
  logic                id_rt_used;
  logic                id_regwrite;
  logic [RA_W-1:0]     id_rd;
  logic [1:0]          id_lat_class;
  logic                flush;
  logic                PCWrite;
  logic                IFID_Write;
  logic                bubble_idex;
  logic                div_busy;
  logic [NUM_REGS-1:0] pending;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_regwrite, id_rd,
           id_lat_class, flush,
    input  PCWrite, IFID_Write, bubble_idex, div_busy, pending
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_regwrite, id_rd,
           id_lat_class, flush,
    output PCWrite, IFID_Write, bubble_idex, div_busy, pending
  );
endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// Load / count-down counter that holds at zero; one per tracked register plus the divider.
module sb_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (i_load)         r_cnt <= i_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: stalls ID until every operand is forwardable,
// blocks out-of-order write retirement, and serialises the non-pipelined divider.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 12,
  parameter int CNT_W    = 4
) (
  input  logic          clock,
  input  logic          reset,
  hazard_scoreboard_if.slave sb
);
  logic [CNT_W-1:0]    w_cnt [NUM_REGS];
  logic [CNT_W-1:0]    w_div_cnt;
  logic [CNT_W-1:0]    w_req;
  logic [NUM_REGS-1:0] w_pending;
  logic                w_raw, w_waw, w_struct, w_stall, w_issue;

  always_comb begin
    w_req = '0;
    case (sb.id_lat_class)
      LAT_LOAD: w_req = CNT_W'(LOAD_LAT - 1);
      LAT_MUL:  w_req = CNT_W'(MUL_LAT - 1);
      LAT_DIV:  w_req = CNT_W'(DIV_LAT - 1);
      default:  w_req = '0;
    endcase
  end

  // r0 is hardwired, so its slot reads as permanently clear
  assign w_cnt[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clock),
      .rst_n (reset),
      .i_load(w_issue && sb.id_regwrite && (sb.id_rd == RA_W'(i))),
      .i_val (w_req),
      .o_cnt (w_cnt[i])
    );
  end

  sb_counter #(.CNT_W(CNT_W)) u_div_cnt (
    .clk   (clock),
    .rst_n (reset),
    .i_load(w_issue && (sb.id_lat_class == LAT_DIV)),
    .i_val (CNT_W'(DIV_LAT - 1)),
    .o_cnt (w_div_cnt)
  );

  assign w_raw = (sb.id_rs_used && (sb.id_rs != '0) && (w_cnt[sb.id_rs] != '0)) ||
                 (sb.id_rt_used && (sb.id_rt != '0) && (w_cnt[sb.id_rt] != '0));
  // a younger write must not land before an older, slower one to the same register
  assign w_waw    = sb.id_regwrite && (sb.id_rd != '0) && (w_cnt[sb.id_rd] > w_req);
  assign w_struct = (sb.id_lat_class == LAT_DIV) && (w_div_cnt != '0);
  assign w_stall  = sb.id_valid && !sb.flush && (w_raw || w_waw || w_struct);
  assign w_issue  = sb.id_valid && !w_stall && !sb.flush;

  always_comb begin
    w_pending = '0;
    for (int i = 1; i < NUM_REGS; i++) w_pending[i] = (w_cnt[i] != '0);
  end

  assign sb.PCWrite     = !w_stall;
  assign sb.IFID_Write  = !w_stall;
  assign sb.bubble_idex = w_stall;
  assign sb.div_busy    = (w_div_cnt != '0);
  assign sb.pending     = w_pending;
endmodule
